cpu_core_pipe: RTL and testbench
================================

# cpu_core_pipe

Parametrised two-stage (fetch/execute) accumulator CPU core: successor of the fixed 4-bit CPU top, with configurable data and address width, an instruction-valid fetch handshake, a zero flag plus extra opcodes, and a valid/ready output port that back-pressures the pipeline. Sits between instruction ROM (`address` → `D_BUS`) and board I/O; A/B registers are exported for debug display.

## Interface
- `DATA_W`, 4, width of A, B, immediate, in_port, out_port (≥ 2)
- `ADDR_W`, 12, program counter / `address` width (≥ 2)
- Local: `INST_W` = 4 + `DATA_W`; opcode = `D_BUS[INST_W-1:DATA_W]`, imm = `D_BUS[DATA_W-1:0]`
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `D_BUS`  in  INST_W  instruction word for `address`
- `inst_valid`  in  1  `D_BUS` holds a valid instruction this cycle
- `in_port`  in  DATA_W  input port, sampled by IN
- `out_ready`  in  1  sink accepts `out_port`
- `address`  out  ADDR_W  fetch address = PC (registered PC, direct)
- `A_reg_out`, `B_reg_out`  out  DATA_W  register A / B
- `out_port`  out  DATA_W  output data register
- `out_valid`  out  1  `out_port` holds unaccepted data
- `cflag`, `zflag`  out  1  carry / zero flags

## Operation
- Fetch: if `inst_valid` and not stall: IR ← `D_BUS`, ir_v ← 1, PC ← PC+1 (wraps mod 2^ADDR_W). If `!inst_valid`: ir_v ← 0 (bubble), PC holds.
- Execute acts on IR only when ir_v=1. Opcodes:
  - 0000 ADD A,imm; 0101 ADD B,imm; 1000 ADD A,B (A←A+B): sum DATA_W+1 bits, C ← bit DATA_W, Z ← (low DATA_W bits == 0)
  - 0011 MOV A,imm; 0111 MOV B,imm; 0001 MOV A,B; 0100 MOV B,A
  - 0010 IN A; 0110 IN B (sample `in_port` at execute edge)
  - 1001 OUT B; 1011 OUT imm
  - 1111 JMP; 1110 JNC (C=0); 1100 JC (C=1); 1010 JNZ (Z=0)
  - 1101 and all others: NOP
- Flags change only on ADD; all other ops (incl. jumps) preserve C, Z.
- Jump target = imm zero-extended to ADDR_W (truncated to ADDR_W if DATA_W > ADDR_W).
- Taken jump: PC ← target, ir_v ← 0 (flush instruction fetched in same cycle). Priority over fetch increment and over `inst_valid`. Not-taken: normal fetch.
- OUT: if !out_valid or out_ready: out_port ← value, out_valid ← 1. Else stall.
- stall = ir_v & IR is OUT & out_valid & !out_ready. During stall: PC, IR, ir_v, A, B, flags hold; `D_BUS` ignored.
- out_valid clears on `out_valid & out_ready` unless an OUT is accepted the same edge (then stays 1, new data).
- Reset: PC=0, A=B=0, C=Z=0, ir_v=0, out_port=0, out_valid=0; applies mid-stall/mid-jump, discarding IR.

## Timing
- Throughput 1 instruction/cycle with continuous `inst_valid`, no taken jumps, no stall.
- Execute result (A, B, flags, out_port) visible 1 edge after the fetching edge; i.e. instruction at address n, fetched on edge k, commits on edge k+1.
- Taken jump penalty: 1 bubble; `address` = target the cycle after the jump executes.
- `address` changes only on clock edges; combinationally independent of `D_BUS`.
- First fetch after reset deassertion: `address`=0 in first cycle.

## Test plan
- Reset then MOV A,3; ADD A,14 (DATA_W=4) → A=1, C=1, Z=0 two edges after last fetch; ADD A,15 on A=1 → A=0, C=1, Z=1.
- JMP 5 at address 2 with address 3 holding MOV A,9 → A unchanged, next `address` sequence 2,3,5,6; exactly one bubble.
- JNC with C=1 not taken, with C=0 taken; JNZ after Z=1 falls through; flags unchanged after jumps and MOVs.
- OUT imm 7 with out_ready=0, then OUT B → out_port=7 held, pipeline stalls (address frozen) until out_ready=1; then out_port=B, out_valid stays 1.
- `inst_valid` toggling 1,0,1 with MOV/ADD stream → PC holds on 0 cycles, results identical to continuous run; reset asserted during stall → all outputs 0, out_valid=0, address=0 next edge.
- DATA_W=8, ADDR_W=6: ADD A,0xFF on A=1 → A=0x00, C=1, Z=1; JMP 0x45 → address=0x05.

Source files
------------

// File: rtl/cpu_core_pipe.sv
// cpu_core_pipe: two-stage fetch/execute accumulator CPU with valid/ready output port
// Ports: clock/reset (sync, active-high); D_BUS/inst_valid instruction fetch for address;
//        in_port sampled by IN; out_port/out_valid/out_ready output handshake;
//        A_reg_out/B_reg_out debug registers; cflag/zflag carry and zero flags.
module cpu_core_pipe #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  localparam int INST_W = 4 + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] D_BUS,
  input  logic              inst_valid,
  input  logic [DATA_W-1:0] in_port,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] A_reg_out,
  output logic [DATA_W-1:0] B_reg_out,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              cflag,
  output logic              zflag
);
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] ir;
  logic ir_v, stall, taken, is_out, is_add;
  logic [3:0] op;
  logic [DATA_W-1:0] imm, add_x, add_y, out_val;
  logic [DATA_W:0] sum;
  logic [ADDR_W+DATA_W-1:0] target_ext;
  assign op = ir[INST_W-1:DATA_W];
  assign imm = ir[DATA_W-1:0];
  assign address = pc;
  always_comb begin
    is_out = ir_v & (op == 4'b1001 | op == 4'b1011);
    is_add = ir_v & (op == 4'b0000 | op == 4'b0101 | op == 4'b1000);
    stall = is_out & out_valid & ~out_ready;
    taken = ir_v & (op == 4'b1111 | (op == 4'b1110 & ~cflag) | (op == 4'b1100 & cflag) | (op == 4'b1010 & ~zflag));
    add_x = op == 4'b0101 ? B_reg_out : A_reg_out;
    add_y = op == 4'b1000 ? B_reg_out : imm;
    sum = {1'b0, add_x} + {1'b0, add_y};
    out_val = op == 4'b1001 ? B_reg_out : imm;
    // zero-extend then keep the low ADDR_W bits, covering both wider and narrower data paths
    target_ext = {{ADDR_W{1'b0}}, imm};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
      ir_v <= 1'b0;
      A_reg_out <= '0;
      B_reg_out <= '0;
      cflag <= 1'b0;
      zflag <= 1'b0;
      out_port <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (ir_v)
        case (op)
          4'b0000, 4'b1000: A_reg_out <= sum[DATA_W-1:0];
          4'b0101: B_reg_out <= sum[DATA_W-1:0];
          4'b0011: A_reg_out <= imm;
          4'b0111: B_reg_out <= imm;
          4'b0001: A_reg_out <= B_reg_out;
          4'b0100: B_reg_out <= A_reg_out;
          4'b0010: A_reg_out <= in_port;
          4'b0110: B_reg_out <= in_port;
          default: ;
        endcase
      if (is_add) begin
        cflag <= sum[DATA_W];
        zflag <= sum[DATA_W-1:0] == '0;
      end
      // an accepted OUT reloads the port, so valid stays high across a handover
      if (is_out) begin
        out_port <= out_val;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      // a taken jump flushes whatever is fetched this edge
      if (taken) begin
        pc <= target_ext[ADDR_W-1:0];
        ir_v <= 1'b0;
      end else if (inst_valid) begin
        ir <= D_BUS;
        ir_v <= 1'b1;
        pc <= pc + ADDR_W'(1);
      end else ir_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_core_pipe.sv
// tb_cpu_core_pipe: randomized and directed checks of cpu_core_pipe against an instruction-level model
module tb_cpu_core_pipe;
  logic clock = 0, reset = 1, inst_valid = 0, out_ready = 0;
  logic [3:0] in_port = 0;
  logic [7:0] d_bus;
  logic [11:0] address;
  logic [3:0] a_o, b_o, out_port;
  logic out_valid, cflag, zflag;
  logic [7:0] rom [4096];
  int total = 0, passed = 0;
  int m_pc, m_ir, m_irv, m_a, m_b, m_c, m_z, m_out, m_ov;
  logic r8 = 1, iv8 = 0;
  logic [11:0] d8 = 0;
  logic [5:0] adr8;
  logic [7:0] a8, b8, o8;
  logic ov8, c8, z8;
  always #5 clock = ~clock;
  assign d_bus = rom[address];
  cpu_core_pipe dut (
    .clock(clock), .reset(reset), .D_BUS(d_bus), .inst_valid(inst_valid), .in_port(in_port),
    .out_ready(out_ready), .address(address), .A_reg_out(a_o), .B_reg_out(b_o),
    .out_port(out_port), .out_valid(out_valid), .cflag(cflag), .zflag(zflag)
  );
  cpu_core_pipe #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clock(clock), .reset(r8), .D_BUS(d8), .inst_valid(iv8), .in_port(8'd0),
    .out_ready(1'b1), .address(adr8), .A_reg_out(a8), .B_reg_out(b8),
    .out_port(o8), .out_valid(ov8), .cflag(c8), .zflag(z8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic model_step;
    int op, imm, s;
    bit tk;
    op = m_ir >> 4;
    imm = m_ir & 15;
    tk = 0;
    if (reset) begin
      m_pc = 0; m_irv = 0; m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_out = 0; m_ov = 0;
    end else if (!(m_irv != 0 && (op == 9 || op == 11) && m_ov != 0 && !out_ready)) begin
      if (m_ov != 0 && out_ready) m_ov = 0;
      if (m_irv != 0)
        case (op)
          0: begin s = m_a + imm; m_a = s % 16; m_c = s / 16; m_z = int'(m_a == 0); end
          5: begin s = m_b + imm; m_b = s % 16; m_c = s / 16; m_z = int'(m_b == 0); end
          8: begin s = m_a + m_b; m_a = s % 16; m_c = s / 16; m_z = int'(m_a == 0); end
          3: m_a = imm;
          7: m_b = imm;
          1: m_a = m_b;
          4: m_b = m_a;
          2: m_a = int'(in_port);
          6: m_b = int'(in_port);
          9: begin m_out = m_b; m_ov = 1; end
          11: begin m_out = imm; m_ov = 1; end
          15: tk = 1;
          14: tk = m_c == 0;
          12: tk = m_c != 0;
          10: tk = m_z == 0;
          default: ;
        endcase
      if (tk) begin
        m_pc = imm;
        m_irv = 0;
      end else if (inst_valid) begin
        m_ir = int'(rom[m_pc]);
        m_irv = 1;
        m_pc = (m_pc + 1) % 4096;
      end else m_irv = 0;
    end
  endtask
  task automatic tick;
    @(posedge clock);
    model_step();
    #1;
    chk("address", address, m_pc);
    chk("A", a_o, m_a);
    chk("B", b_o, m_b);
    chk("C", cflag, m_c);
    chk("Z", zflag, m_z);
    chk("out_port", out_port, m_out);
    chk("out_valid", out_valid, m_ov);
  endtask
  task automatic clr_rom;
    for (int i = 0; i < 4096; i++) rom[i] = 8'hD0;
  endtask
  task automatic do_reset;
    reset = 1;
    tick();
    reset = 0;
  endtask
  initial begin
    clr_rom();
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'h0F;
    inst_valid = 1;
    do_reset();
    chk("rst_addr", address, 0);
    chk("rst_ov", out_valid, 0);
    repeat (3) tick();
    chk("add14_A", a_o, 1); chk("add14_C", cflag, 1); chk("add14_Z", zflag, 0);
    tick();
    chk("add15_A", a_o, 0); chk("add15_C", cflag, 1); chk("add15_Z", zflag, 1);
    clr_rom();
    rom[0] = 8'h32; rom[2] = 8'hF5; rom[3] = 8'h39;
    do_reset();
    repeat (2) tick();
    chk("jmp_seq0", address, 2);
    tick(); chk("jmp_seq1", address, 3);
    tick(); chk("jmp_seq2", address, 5);
    tick(); chk("jmp_seq3", address, 6);
    tick(); chk("jmp_A", a_o, 2);
    clr_rom();
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE8; rom[3] = 8'hA8; rom[4] = 8'h00; rom[5] = 8'hE9;
    do_reset();
    repeat (5) tick();
    chk("jnz_fall_addr", address, 5); chk("jnz_C", cflag, 1); chk("jnz_Z", zflag, 1);
    repeat (2) tick();
    chk("jnc_taken_addr", address, 9); chk("jnc_C", cflag, 0); chk("jnc_Z", zflag, 1);
    clr_rom();
    rom[0] = 8'h74; rom[1] = 8'hB7; rom[2] = 8'h90;
    out_ready = 0;
    do_reset();
    repeat (6) tick();
    chk("stall_out", out_port, 7); chk("stall_addr", address, 3); chk("stall_ov", out_valid, 1);
    out_ready = 1;
    tick();
    chk("release_out", out_port, 4); chk("release_ov", out_valid, 1); chk("release_addr", address, 4);
    tick();
    chk("drain_ov", out_valid, 0);
    out_ready = 0;
    do_reset();
    repeat (5) tick();
    reset = 1;
    tick();
    chk("rst_stall_addr", address, 0); chk("rst_stall_B", b_o, 0);
    chk("rst_stall_out", out_port, 0); chk("rst_stall_ov", out_valid, 0);
    reset = 0;
    clr_rom();
    rom[0] = 8'h33; rom[1] = 8'h05;
    do_reset();
    tick();
    inst_valid = 0;
    tick(); chk("bubble_addr", address, 1);
    inst_valid = 1;
    repeat (2) tick();
    chk("bubble_A", a_o, 8);
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 63) == 0;
      inst_valid = $urandom_range(0, 4) != 0;
      out_ready = $urandom_range(0, 1) == 1;
      in_port = 4'($urandom);
      tick();
    end
    r8 = 1;
    @(posedge clock); #1;
    r8 = 0; iv8 = 1; d8 = 12'h301;
    @(posedge clock); #1;
    d8 = 12'h0FF;
    @(posedge clock); #1;
    d8 = 12'hF45;
    @(posedge clock); #1;
    chk("w8_A", a8, 0); chk("w8_C", c8, 1); chk("w8_Z", z8, 1);
    iv8 = 0;
    @(posedge clock); #1;
    chk("w8_jmp_addr", adr8, 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
